// File: rtl/cdb_bus_master.sv
// Central CDB grant arbiter: picks up to two requesters per cycle (aged first, then
// round-robin) and drives a registered select address/valid per CDB plus a grant vector.
module cdb_bus_master #(
  parameter int NUM_REQ   = 8,
  parameter int AGE_LIMIT = 15
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [1:0]         i_bus_stall,
  output logic [1:0][7:0]    o_select_addr,
  output logic [1:0]         o_select_valid,
  output logic [NUM_REQ-1:0] o_grant
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [AGE_W-1:0] age_t;

  localparam age_t AGE_MAX = age_t'(AGE_LIMIT);

  function automatic idx_t wrap_idx(input idx_t base, input int off);
    return idx_t'((int'(base) + off) % NUM_REQ);
  endfunction

  function automatic idx_t inc_idx(input idx_t idx);
    return (idx == idx_t'(NUM_REQ - 1)) ? '0 : idx_t'(idx + 1'b1);
  endfunction

  idx_t               rr_ptr, rr_ptr_nxt;
  age_t               age_q [NUM_REQ];
  age_t               age_d [NUM_REQ];

  logic [NUM_REQ-1:0] eligible, aged, rr_cand, grant_d;
  logic               any_aged;
  idx_t               aged_idx;
  logic               rr_a_vld, rr_b_vld;
  idx_t               rr_a_idx, rr_b_idx;
  logic               pick_a_vld, pick_b_vld;
  idx_t               pick_a_idx, pick_b_idx;
  logic               grant_a, grant_b, bus_a;
  logic [1:0]         valid_d;
  logic [1:0][7:0]    addr_d;

  // The current grant vector doubles as the one-cycle mask.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    eligible = i_req & ~o_grant;
    aged     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      aged[k] = eligible[k] && (age_q[k] == AGE_MAX);
    end
    any_aged = |aged;
    aged_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (aged[k]) aged_idx = idx_t'(k);
    end

    rr_cand = eligible;
    if (any_aged) rr_cand[aged_idx] = 1'b0;
    rr_a_vld = 1'b0;
    rr_b_vld = 1'b0;
    rr_a_idx = '0;
    rr_b_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rr_cand[wrap_idx(rr_ptr, i)]) begin
        if (!rr_a_vld) begin
          rr_a_vld = 1'b1;
          rr_a_idx = wrap_idx(rr_ptr, i);
        end else if (!rr_b_vld) begin
          rr_b_vld = 1'b1;
          rr_b_idx = wrap_idx(rr_ptr, i);
        end
      end
    end

    // An aged winner takes the first slot; the second slot is always round-robin.
    pick_a_vld = any_aged | rr_a_vld;
    pick_a_idx = any_aged ? aged_idx : rr_a_idx;
    pick_b_vld = any_aged ? rr_a_vld : rr_b_vld;
    pick_b_idx = any_aged ? rr_a_idx : rr_b_idx;

    grant_a = pick_a_vld && (i_bus_stall != 2'b11);
    bus_a   = i_bus_stall[0];
    grant_b = pick_b_vld && (i_bus_stall == 2'b00);

    valid_d = '0;
    addr_d  = o_select_addr;
    grant_d = '0;
    if (grant_a) begin
      valid_d[bus_a]   = 1'b1;
      addr_d[bus_a]    = 8'(pick_a_idx);
      grant_d[pick_a_idx] = 1'b1;
    end
    if (grant_b) begin
      valid_d[1]       = 1'b1;
      addr_d[1]        = 8'(pick_b_idx);
      grant_d[pick_b_idx] = 1'b1;
    end

    rr_ptr_nxt = rr_ptr;
    if (grant_b) rr_ptr_nxt = inc_idx(pick_b_idx);
    else if (grant_a && !any_aged) rr_ptr_nxt = inc_idx(pick_a_idx);

    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_d[k] || !i_req[k]) age_d[k] = '0;
      else if (o_grant[k] || (age_q[k] == AGE_MAX)) age_d[k] = age_q[k];
      else age_d[k] = age_t'(age_q[k] + 1'b1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_select_addr  <= '0;
      o_select_valid <= '0;
      o_grant        <= '0;
      rr_ptr         <= '0;
      // NOTE: the age array is reset too, since a stale age would pre-empt round-robin.
      for (int k = 0; k < NUM_REQ; k++) age_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      o_select_addr  <= addr_d;
      o_select_valid <= valid_d;
      o_grant        <= grant_d;
      rr_ptr         <= rr_ptr_nxt;
      for (int k = 0; k < NUM_REQ; k++) age_q[k] <= age_d[k];
    end
  end

endmodule
